// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: payload plus valid bit, with flush, bubble
// insertion, hold on downstream stall, and saturating per-stage event counters.
module pipe_stage_reg #(
   parameter int                DATA_W          = 110,
   parameter int                STALL_W         = 6,
   parameter int                STAGE_IDX       = 3,
   parameter logic [DATA_W-1:0] NOP_DATA        = {DATA_W{1'b0}},
   parameter bit                CLEAR_ON_BUBBLE = 1'b1,
   parameter int                CNT_W           = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   input  logic               cnt_clr,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   bubble_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   // out_valid qualifies out_data: downstream consumes out_data only in cycles
   // where out_valid=1; there is no ready, backpressure arrives via stall.
   typedef enum logic [1:0] {
      ACT_ADVANCE,
      ACT_FLUSH,
      ACT_BUBBLE,
      ACT_HOLD
   } action_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   action_t action;
   logic    up;
   logic    dn;
   logic    unused_stall;

   generate
      if (STAGE_IDX < 0 || STAGE_IDX >= STALL_W) begin : g_bad_idx
         $error("pipe_stage_reg: STAGE_IDX out of range of the stall vector");
      end
      // The last stage has no downstream stall bit, so it can only bubble.
      if (STAGE_IDX >= STALL_W - 1) begin : g_last_stage
         assign dn = 1'b0;
      end else begin : g_mid_stage
         assign dn = stall[STAGE_IDX+1];
      end
   endgenerate

   assign up           = stall[STAGE_IDX];
   assign unused_stall = ^stall;

   always_comb begin
      action = ACT_ADVANCE;
      if (flush) begin
         action = ACT_FLUSH;
      end else if (up && !dn) begin
         action = ACT_BUBBLE;
      end else if (up) begin
         action = ACT_HOLD;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= NOP_DATA;
      end else begin
         case (action)
            ACT_FLUSH: begin
               out_valid <= 1'b0;
               out_data  <= NOP_DATA;
            end
            ACT_BUBBLE: begin
               out_valid <= 1'b0;
               if (CLEAR_ON_BUBBLE) begin
                  out_data <= NOP_DATA;
               end
            end
            ACT_HOLD: begin
               out_valid <= out_valid;
               out_data  <= out_data;
            end
            default: begin
               out_valid <= in_valid;
               out_data  <= in_data;
            end
         endcase
      end
   end

   // A flush only counts as a kill if the stage held a real instruction.
   always_ff @(posedge clk) begin
      if (!rst || cnt_clr) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else begin
         if (up && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         if (action == ACT_BUBBLE && bubble_cnt != CNT_MAX) begin
            bubble_cnt <= bubble_cnt + CNT_ONE;
         end
         if (flush && out_valid && flush_cnt != CNT_MAX) begin
            flush_cnt <= flush_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: four instances (default, keep-on-bubble, 4-bit
// counters, last stage with non-zero NOP) checked against a reference model.
module tb_pipe_stage_reg;

   localparam int DW = 110;
   localparam logic [DW-1:0] NOP_LAST = 110'h5A5;

   typedef struct packed {
      logic          v;
      logic [DW-1:0] d;
      logic [15:0]   sc;
      logic [15:0]   bc;
      logic [15:0]   fc;
   } st_t;
   localparam int SW = $bits(st_t);

   logic          clk = 1'b0;
   logic          rst;
   logic [5:0]    stall;
   logic          flush;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          cnt_clr;

   logic          v_main, v_keep, v_sat, v_last;
   logic [DW-1:0] d_main, d_keep, d_sat, d_last;
   logic [15:0]   sc_main, bc_main, fc_main;
   logic [15:0]   sc_keep, bc_keep, fc_keep;
   logic [3:0]    sc_sat, bc_sat, fc_sat;
   logic [15:0]   sc_last, bc_last, fc_last;

   logic [SW-1:0] exp_q[$];
   st_t m_main, m_keep, m_sat, m_last;
   int  n_checks = 0;
   int  n_errors = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- DUT instances ----------------
   pipe_stage_reg #(.DATA_W(DW)) u_main (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .in_data(in_data), .out_valid(v_main), .out_data(d_main), .cnt_clr(cnt_clr),
      .stall_cnt(sc_main), .bubble_cnt(bc_main), .flush_cnt(fc_main));

   pipe_stage_reg #(.DATA_W(DW), .CLEAR_ON_BUBBLE(1'b0)) u_keep (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .in_data(in_data), .out_valid(v_keep), .out_data(d_keep), .cnt_clr(cnt_clr),
      .stall_cnt(sc_keep), .bubble_cnt(bc_keep), .flush_cnt(fc_keep));

   pipe_stage_reg #(.DATA_W(DW), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .in_data(in_data), .out_valid(v_sat), .out_data(d_sat), .cnt_clr(cnt_clr),
      .stall_cnt(sc_sat), .bubble_cnt(bc_sat), .flush_cnt(fc_sat));

   pipe_stage_reg #(.DATA_W(DW), .STAGE_IDX(5), .NOP_DATA(NOP_LAST)) u_last (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .in_data(in_data), .out_valid(v_last), .out_data(d_last), .cnt_clr(cnt_clr),
      .stall_cnt(sc_last), .bubble_cnt(bc_last), .flush_cnt(fc_last));

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model of one register update, reading the current bench inputs.
   function automatic st_t model(st_t s, int idx, bit cob, logic [DW-1:0] nop,
                                 logic [15:0] cmax);
      st_t  n;
      logic up;
      logic dn;
      n  = s;
      up = stall[idx];
      dn = 1'b0;
      if (idx < 5) dn = stall[idx+1];
      if (!rst) begin
         n   = '0;
         n.d = nop;
         return n;
      end
      if (flush) begin
         n.v = 1'b0;
         n.d = nop;
      end else if (up && !dn) begin
         n.v = 1'b0;
         if (cob) n.d = nop;
      end else if (!up) begin
         n.v = in_valid;
         n.d = in_data;
      end
      if (cnt_clr) begin
         n.sc = '0;
         n.bc = '0;
         n.fc = '0;
      end else begin
         if (up && s.sc < cmax) n.sc = s.sc + 16'd1;
         if (!flush && up && !dn && s.bc < cmax) n.bc = s.bc + 16'd1;
         if (flush && s.v && s.fc < cmax) n.fc = s.fc + 16'd1;
      end
      return n;
   endfunction

   task automatic cmp_inst(input string name, input st_t act);
      st_t e;
      if (exp_q.size() == 0) begin
         check({name, ".queue"}, DW'(0), DW'(1));
         return;
      end
      e = st_t'(exp_q.pop_front());
      check({name, ".valid"},  DW'(act.v),  DW'(e.v));
      check({name, ".data"},   act.d,       e.d);
      check({name, ".stall"},  DW'(act.sc), DW'(e.sc));
      check({name, ".bubble"}, DW'(act.bc), DW'(e.bc));
      check({name, ".flush"},  DW'(act.fc), DW'(e.fc));
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic r, input logic [5:0] s, input logic f,
                       input logic iv, input logic [DW-1:0] id, input logic c);
      rst      = r;
      stall    = s;
      flush    = f;
      in_valid = iv;
      in_data  = id;
      cnt_clr  = c;
      m_main = model(m_main, 3, 1'b1, '0, 16'hFFFF);     exp_q.push_back(m_main);
      m_keep = model(m_keep, 3, 1'b0, '0, 16'hFFFF);     exp_q.push_back(m_keep);
      m_sat  = model(m_sat,  3, 1'b1, '0, 16'h000F);     exp_q.push_back(m_sat);
      m_last = model(m_last, 5, 1'b1, NOP_LAST, 16'hFFFF); exp_q.push_back(m_last);
      @(posedge clk);
      #1;
      cmp_inst("main", '{v_main, d_main, sc_main, bc_main, fc_main});
      cmp_inst("keep", '{v_keep, d_keep, sc_keep, bc_keep, fc_keep});
      cmp_inst("sat",  '{v_sat, d_sat, 16'(sc_sat), 16'(bc_sat), 16'(fc_sat)});
      cmp_inst("last", '{v_last, d_last, sc_last, bc_last, fc_last});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [5:0]    rs;
      logic [DW-1:0] rd;
      int            k;
      m_main = '0;
      m_keep = '0;
      m_sat  = '0;
      m_last = '0;

      // reset then advance
      step(1'b0, 6'b000000, 1'b0, 1'b1, DW'(12'h111), 1'b0);
      step(1'b0, 6'b000000, 1'b0, 1'b1, DW'(12'h222), 1'b0);
      check("rst.valid", DW'(v_main), DW'(0));
      check("rst.data_last", d_last, NOP_LAST);
      step(1'b1, 6'b000000, 1'b0, 1'b1, DW'(12'hABC), 1'b0);
      check("adv.valid", DW'(v_main), DW'(1));
      check("adv.data", d_main, DW'(12'hABC));

      // bubble
      step(1'b1, 6'b000000, 1'b0, 1'b1, DW'(8'h55), 1'b0);
      step(1'b1, 6'b001000, 1'b0, 1'b1, DW'(8'h99), 1'b0);
      check("bub.valid", DW'(v_main), DW'(0));
      check("bub.data", d_main, DW'(0));
      check("bub.bcnt", DW'(bc_main), DW'(1));
      check("bub.scnt", DW'(sc_main), DW'(1));
      check("bub.keep_data", d_keep, DW'(8'h55));

      // hold
      step(1'b1, 6'b000000, 1'b0, 1'b1, DW'(8'h77), 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 6'b011000, 1'b0, 1'b0, DW'($urandom), 1'b0);
      end
      check("hold.data", d_main, DW'(8'h77));
      check("hold.valid", DW'(v_main), DW'(1));
      check("hold.scnt", DW'(sc_main), DW'(3));
      check("hold.bcnt", DW'(bc_main), DW'(0));
      step(1'b1, 6'b000000, 1'b0, 1'b1, DW'(12'h123), 1'b1);
      check("hold.release", d_main, DW'(12'h123));

      // flush priority over hold
      step(1'b1, 6'b011000, 1'b1, 1'b1, DW'(12'h456), 1'b0);
      check("fl.valid", DW'(v_main), DW'(0));
      check("fl.fcnt", DW'(fc_main), DW'(1));
      check("fl.scnt", DW'(sc_main), DW'(1));
      check("fl.bcnt", DW'(bc_main), DW'(0));
      step(1'b1, 6'b000000, 1'b1, 1'b1, DW'(12'h789), 1'b0);
      check("fl.empty_fcnt", DW'(fc_main), DW'(1));

      // saturation and clear
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 6'b001000, 1'b0, 1'b1, DW'(i), 1'b0);
      end
      check("sat.scnt", DW'(sc_sat), DW'(15));
      check("sat.bcnt", DW'(bc_sat), DW'(15));
      step(1'b1, 6'b001000, 1'b0, 1'b1, DW'(0), 1'b1);
      check("sat.clr", DW'(sc_sat), DW'(0));

      // last stage bubbles, then reset mid-stall/flush
      step(1'b1, 6'b000000, 1'b0, 1'b1, DW'(12'h321), 1'b0);
      step(1'b1, 6'b100000, 1'b0, 1'b1, DW'(12'hEEE), 1'b0);
      check("last.valid", DW'(v_last), DW'(0));
      check("last.data", d_last, NOP_LAST);
      check("last.bcnt", DW'(bc_last), DW'(1));
      step(1'b0, 6'b100000, 1'b1, 1'b1, DW'(12'hFFF), 1'b0);
      check("last.rst_scnt", DW'(sc_last), DW'(0));
      check("last.rst_data", d_last, NOP_LAST);

      // random monotone stall vectors with occasional flush, clear and reset
      for (int i = 0; i < 300; i++) begin
         k  = $urandom_range(0, 6);
         rs = '0;
         for (int b = 0; b < 6; b++) if (b < k) rs[b] = 1'b1;
         rd = {$urandom, $urandom, $urandom, $urandom};
         step(($urandom_range(0, 49) != 0), rs, ($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 1)), rd, ($urandom_range(0, 15) == 0));
      end

      check("queue.drained", DW'(exp_q.size()), DW'(0));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
